load_store_unit: RTL and testbench

Initiator for the single-port data memory. It sits between the MEM pipeline stage and the word-addressed data RAM, which writes on the rising clock edge and reads on the falling edge. The unit accepts one load or store per handshake, drives Address/WriteData/MemWrite/MemRead, and returns load data or a completion pulse. Byte and halfword accesses are provided over the word-only RAM: loads use extract and sign-extend, stores use read-modify-write.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/load_store_unit_lane_align.sv | 41 ++++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared encodings, FSM states and request legality check.
// LSU_SUBWORD_EN adds the read-modify-write states for byte/half stores.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef LSU_SUBWORD_EN
    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR
    } state_t;
`endif

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and
// lane merge for read-modify-write stores. Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_data
);

    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;

    assign sh   = {off, 3'b000};
    assign lane = ld_word >> sh;

    always_comb begin
        ld_data = ld_word;
        mask    = 32'hFFFF_FFFF;
        unique case (1'b1)
            size == SZ_BYTE: begin
                ld_data = {{24{~uns & lane[7]}}, lane[7:0]};
                mask    = 32'h0000_00FF << sh;
            end
            size == SZ_HALF: begin
                ld_data = {{16{~uns & lane[15]}}, lane[15:0]};
                mask    = 32'h0000_FFFF << sh;
            end
            default: ;
        endcase
    end

    assign st_data = (st_old & ~mask) | ((st_wdata << sh) & mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for the single-port word RAM.
// Define LSU_SUBWORD_EN for byte/half access via extract and RMW.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] ReadData
);

    state_t            state_q;
    state_t            state_d;
    logic              err_pend;
    logic              accept;
    logic              bad;
    logic              is_word;
    logic              done;
    logic [DATA_W-1:0] ld_data;

    assign accept    = req_valid && req_ready;
    assign is_word   = req_size == SZ_WORD;
    assign req_ready = state_q == IDLE;

`ifdef LSU_SUBWORD_EN
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] st_data;

    assign bad = misaligned(req_size, req_addr[1:0]);

    lsu_lane_align u_align (
        .ld_word  (ReadData),
        .off      (off_q),
        .size     (size_q),
        .uns      (uns_q),
        .ld_data  (ld_data),
        .st_old   (ReadData),
        .st_wdata (wdata_q),
        .st_data  (st_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            off_q   <= '0;
            size_q  <= SZ_WORD;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
        end
    end
`else
    logic unused;

    assign bad     = !is_word || misaligned(req_size, req_addr[1:0]);
    assign ld_data = ReadData;
    assign unused  = req_unsigned;
`endif

    always_comb begin
        state_d  = state_q;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && !bad) begin
                    if (!req_write)
                        state_d = RD;
`ifdef LSU_SUBWORD_EN
                    else if (!is_word)
                        state_d = RMW_RD;
`endif
                    else
                        state_d = WR;
                end
            end
            RD: begin
                MemRead = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            WR: begin
                MemWrite = 1'b1;
                done     = 1'b1;
                state_d  = IDLE;
            end
`ifdef LSU_SUBWORD_EN
            RMW_RD: begin
                MemRead = 1'b1;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                MemWrite = 1'b1;
                done     = 1'b1;
                state_d  = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Errors are held one cycle so they respond with the same latency as loads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            err_pend   <= 1'b0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            Address    <= '0;
            WriteData  <= '0;
        end else begin
            state_q    <= state_d;
            err_pend   <= accept && bad;
            resp_valid <= err_pend || done;
            resp_error <= err_pend;
            if (accept) begin
                Address <= {req_addr[ADDR_W-1:2], 2'b00};
                if (req_write && is_word && !bad)
                    WriteData <= req_wdata;
            end
            if (state_q == RD)
                resp_rdata <= ld_data;
`ifdef LSU_SUBWORD_EN
            if (state_q == RMW_RD)
                WriteData <= st_data;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus scoreboard,
// with a behavioural RAM (write on rising edge, read on falling edge).
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] X = 2'b11;
`ifdef LSU_SUBWORD_EN
    localparam bit SW = 1'b1;
`else
    localparam bit SW = 1'b0;
`endif
    localparam int NV = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData = '0;

    always #5 clock = ~clock;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .Address      (Address),
        .WriteData    (WriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .ReadData     (ReadData)
    );

    logic [31:0] mem [16];
    always @(posedge clock) if (MemWrite) mem[Address[5:2]] <= WriteData;
    always @(negedge clock) if (MemRead) ReadData <= mem[Address[5:2]];

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        bit          un;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] erd;
        bit          eerr;
        logic [31:0] ewd;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        bit          err;
        bit          ld;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wd;
        logic [31:0] addr;
        int          acc;
        int          id;
    } exp_t;

    vec_t        tbl [NV];
    exp_t        sbq [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          nrd = 0;
    int          nwr = 0;
    logic [31:0] seen_wd = '0;
    logic [31:0] seen_addr = '0;
    logic [31:0] last_rd = '0;

    always @(posedge clock) cyc++;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [1:0] sz,
                                input bit un, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] erd,
                                input bit eerr, input logic [31:0] ewd);
        vec_t v;
        v.wr = wr; v.sz = sz; v.un = un; v.addr = a; v.wd = wd;
        v.erd = erd; v.eerr = eerr; v.ewd = ewd;
        return v;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (MemRead) begin
                nrd++;
                seen_addr = Address;
            end
            if (MemWrite) begin
                nwr++;
                seen_wd = WriteData;
                seen_addr = Address;
            end
            check("rd_wr_excl", {31'b0, MemRead & MemWrite}, 32'd0);
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("err[%0d]", e.id), {31'b0, resp_error}, {31'b0, e.err});
                    check($sformatf("lat[%0d]", e.id), cyc - e.acc, e.lat);
                    check($sformatf("nread[%0d]", e.id), nrd, e.nrd);
                    check($sformatf("nwrite[%0d]", e.id), nwr, e.nwr);
                    if (e.nrd + e.nwr > 0)
                        check($sformatf("addr[%0d]", e.id), seen_addr, e.addr);
                    if (e.nwr > 0)
                        check($sformatf("wdata[%0d]", e.id), seen_wd, e.wd);
                    if (!e.err && e.ld)
                        last_rd = e.rd;
                    if (!e.err)
                        check($sformatf("rdata[%0d]", e.id), resp_rdata, last_rd);
                end
            end
        end
    end

    task automatic wait_idle(input int id);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clock);
            #1;
            n++;
            ok = (sbq.size() == 0) && req_ready;
        end
        if (!ok) begin
            check($sformatf("timeout[%0d]", id), 32'd1, 32'd0);
            sbq.delete();
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid    = 1'b1;
        req_write    = v.wr;
        req_size     = v.sz;
        req_unsigned = v.un;
        req_addr     = v.addr;
        req_wdata    = v.wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        nrd = 0;
        nwr = 0;
    endtask

    task automatic issue(input vec_t v, input int id);
        exp_t e;
        wait_idle(id);
        drive(v);
        e.rd   = v.erd;
        e.err  = v.eerr;
        e.ld   = !v.wr;
        e.lat  = (!v.eerr && v.wr && v.sz != W) ? 2 : 1;
        e.nrd  = v.eerr ? 0 : ((!v.wr || v.sz != W) ? 1 : 0);
        e.nwr  = (v.eerr || !v.wr) ? 0 : 1;
        e.wd   = v.ewd;
        e.addr = {v.addr[31:2], 2'b00};
        e.acc  = cyc;
        e.id   = id;
        sbq.push_back(e);
    endtask

    task automatic abort_at(input vec_t v, input bit rd_phase,
                            input string nm);
        wait_idle(-1);
        drive(v);
        check({nm, "_rd_busy"}, {31'b0, MemRead}, {31'b0, rd_phase});
        check({nm, "_wr_busy"}, {31'b0, MemWrite}, {31'b0, !rd_phase});
        #2;
        reset = 1'b1;
        #1;
        check({nm, "_rd_drop"}, {31'b0, MemRead}, 32'd0);
        check({nm, "_wr_drop"}, {31'b0, MemWrite}, 32'd0);
        check({nm, "_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        last_rd = '0;
        repeat (3) begin
            @(negedge clock);
            check({nm, "_no_resp"}, {31'b0, resp_valid}, 32'd0);
        end
    endtask

    localparam logic [31:0] W8 = SW ? 32'hBEEF3323 : 32'h80223344;

    initial begin
        tbl[0]  = mk(1, W, 0, 32'h4, 32'd54, 0, 0, 32'd54);
        tbl[1]  = mk(0, W, 0, 32'h4, 0, 32'd54, 0, 0);
        tbl[2]  = mk(1, W, 0, 32'h8, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
        tbl[3]  = mk(0, W, 0, 32'h8, 0, 32'hDEADBEEF, 0, 0);
        tbl[4]  = mk(1, W, 0, 32'h8, 32'h11223344, 0, 0, 32'h11223344);
        tbl[5]  = mk(1, B, 0, 32'h9, 32'hAA, 0, !SW, 32'h1122AA44);
        tbl[6]  = mk(0, W, 0, 32'h8, 0,
                     SW ? 32'h1122AA44 : 32'h11223344, 0, 0);
        tbl[7]  = mk(1, W, 0, 32'h8, 32'h80223344, 0, 0, 32'h80223344);
        tbl[8]  = mk(0, B, 0, 32'hB, 0, 32'hFFFFFF80, !SW, 0);
        tbl[9]  = mk(0, B, 1, 32'hB, 0, 32'h00000080, !SW, 0);
        tbl[10] = mk(0, H, 0, 32'hA, 0, 32'hFFFF8022, !SW, 0);
        tbl[11] = mk(0, H, 1, 32'hA, 0, 32'h00008022, !SW, 0);
        tbl[12] = mk(0, W, 0, 32'h6, 0, 0, 1, 0);
        tbl[13] = mk(1, H, 0, 32'h5, 32'h1234, 0, 1, 0);
        tbl[14] = mk(0, X, 0, 32'h0, 0, 0, 1, 0);
        tbl[15] = mk(1, H, 0, 32'hA, 32'hABCDBEEF, 0, !SW, 32'hBEEF3344);
        tbl[16] = mk(0, H, 1, 32'h8, 0, 32'h00003344, !SW, 0);
        tbl[17] = mk(0, W, 0, 32'h8, 0,
                     SW ? 32'hBEEF3344 : 32'h80223344, 0, 0);
        tbl[18] = mk(1, B, 0, 32'h8, 32'h123, 0, !SW, 32'hBEEF3323);
        tbl[19] = mk(0, B, 0, 32'h8, 0, 32'h00000023, !SW, 0);

        #2;
        reset = 1'b1;
        #2;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_error", {31'b0, resp_error}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_address", Address, 32'd0);
        check("rst_wdata", WriteData, 32'd0);
        check("rst_memwrite", {31'b0, MemWrite}, 32'd0);
        check("rst_memread", {31'b0, MemRead}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NV; i++)
            issue(tbl[i], i);

        abort_at(mk(1, W, 0, 32'h8, 32'hCAFEF00D, 0, 0, 0), 1'b0, "abort_wr");
        issue(mk(0, W, 0, 32'h8, 0, W8, 0, 0), 100);
        if (SW) begin
            abort_at(mk(1, B, 0, 32'h9, 32'h55, 0, 0, 0), 1'b1, "abort_rmw");
            issue(mk(0, W, 0, 32'h8, 0, W8, 0, 0), 101);
        end
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
